// File: rtl/sha512_block_ctrl.sv
// SHA-512 block controller: runs one 1024-bit block through an 80-round
// compression (one round per clock), adds the chaining value and presents
// the 512-bit digest over a valid/ready handshake.
module sha512_block_ctrl #(
  parameter int NUM_ROUNDS = 80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] in_block,
  input  logic          in_first,
  input  logic [511:0]  in_hash,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  out_hash,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [63:0] K_TAB [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x);
    return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x);
    return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
  endfunction

  state_t        r_state, w_next;
  logic [6:0]    r_t;
  logic [63:0]   r_w [16];   // W[t..t+15]; r_w[0] feeds the current round
  logic [63:0]   r_h [8];    // chaining value for this block
  logic [63:0]   r_v [8];    // working variables a..h
  logic [511:0]  r_out;
  logic [511:0]  w_hsel;
  logic [511:0]  w_sum;
  logic [63:0]   w_wnew, w_t1, w_t2, w_ki;
  logic          w_accept, w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_t == 7'(NUM_ROUNDS - 1));
  assign w_hsel   = in_first ? IV : in_hash;
  assign w_ki     = K_TAB[r_t];
  // The window always holds the next 16 schedule words, so the word that
  // enters at the tail is W[t+16], built from the words already present.
  assign w_wnew   = sig1(r_w[14]) + r_w[9] + sig0(r_w[1]) + r_w[0];
  assign w_t1     = r_v[7] + (ror64(r_v[4], 14) ^ ror64(r_v[4], 18) ^ ror64(r_v[4], 41))
                  + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + w_ki + r_w[0];
  assign w_t2     = (ror64(r_v[0], 28) ^ ror64(r_v[0], 34) ^ ror64(r_v[0], 39))
                  + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_ROUND;
      S_ROUND: if (w_last)    w_next = S_FINAL;
      S_FINAL:                w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_ROUND) || (r_state == S_FINAL);
  end

  // Round counter
  always_ff @(posedge clk) begin
    if (rst)                      r_t <= '0;
    else if (w_accept)            r_t <= '0;
    else if (r_state == S_ROUND)  r_t <= r_t + 7'd1;
  end

  // Block load, message-schedule window and one compression round per clock
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 16; i++) r_w[i] <= in_block[1023 - 64*i -: 64];
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= w_hsel[511 - 64*i -: 64];
        r_v[i] <= w_hsel[511 - 64*i -: 64];
      end
    end else if (r_state == S_ROUND) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_wnew;
      r_v[0]  <= w_t1 + w_t2;
      r_v[1]  <= r_v[0];
      r_v[2]  <= r_v[1];
      r_v[3]  <= r_v[2];
      r_v[4]  <= r_v[3] + w_t1;
      r_v[5]  <= r_v[4];
      r_v[6]  <= r_v[5];
      r_v[7]  <= r_v[6];
    end
  end

  // Per-word chaining addition, no carry across word boundaries
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) w_sum[511 - 64*i -: 64] = r_h[i] + r_v[i];
  end

  // Digest register, written only by the final step
  always_ff @(posedge clk) begin
    if (rst)                     r_out <= '0;
    else if (r_state == S_FINAL) r_out <= w_sum;
  end

  assign out_hash = r_out;

endmodule
